indirect_ctrl: RTL and testbench

INDIRECT_CTRL -- requirements
Module: indirect_ctrl

---
 rtl/lc3b_types.sv | 12 +
 rtl/indirect_ctrl.sv | 165 ++++++++++++++++
 tb/tb_indirect_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types.
//   lc3b_word      : 16-bit machine word / address
//   lc3b_mem_wmask : per-byte write enable for a 16-bit memory access
package lc3b_types;

   localparam int unsigned WORD_WIDTH  = 16;
   localparam int unsigned WMASK_WIDTH = 2;

   typedef logic [WORD_WIDTH-1:0]  lc3b_word;
   typedef logic [WMASK_WIDTH-1:0] lc3b_mem_wmask;

endpackage

// File: rtl/indirect_ctrl.sv
// Indirect memory controller between the MEM stage and the D-cache.
// Non-indirect requests pass straight through combinationally. Indirect
// requests (LDI/STI) first read a pointer word from the cache, then perform
// the actual read/write at that pointer, returning a single completion pulse.
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   P_mem_* , indirect               MEM-stage request (in)
//   P_mem_resp, P_mem_rdata          completion pulse and read data (out)
//   d_*                              D-cache request (out) / response (in)
//   indirect_count                   saturating count of completed indirect ops
module indirect_ctrl
   import lc3b_types::*;
#(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  lc3b_word             P_mem_address,
   input  logic                 P_mem_read,
   input  logic                 P_mem_write,
   input  lc3b_mem_wmask        P_mem_byte_enable,
   input  lc3b_word             P_mem_wdata,
   input  logic                 indirect,
   output logic                 P_mem_resp,
   output lc3b_word             P_mem_rdata,
   output lc3b_word             d_address,
   output logic                 d_read,
   output logic                 d_write,
   output lc3b_mem_wmask        d_byte_enable,
   output lc3b_word             d_wdata,
   input  lc3b_word             d_rdata,
   input  logic                 d_resp,
   output logic [CNT_WIDTH-1:0] indirect_count
);

   typedef enum logic [1:0] {IDLE, PTR, ACC, DRAIN} state_t;

   state_t   state, state_next;
   lc3b_word ptr, ptr_next;
   logic     cnt_inc;

   // Last cache request issued on the indirect path, replayed while draining
   lc3b_word last_addr, last_addr_next;
   lc3b_word last_wdata, last_wdata_next;
   logic     last_write, last_write_next;

   logic     req;
   logic     wr_only;

   // Simultaneous read and write is treated as a read
   assign req     = P_mem_read | P_mem_write;
   assign wr_only = P_mem_write & ~P_mem_read;

   // State, pointer, counter and drain bookkeeping registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         ptr            <= '0;
         indirect_count <= '0;
         last_addr      <= '0;
         last_wdata     <= '0;
         last_write     <= 1'b0;
      end else begin
         state      <= state_next;
         ptr        <= ptr_next;
         last_addr  <= last_addr_next;
         last_wdata <= last_wdata_next;
         last_write <= last_write_next;
         if (cnt_inc && (indirect_count != '1))
            indirect_count <= indirect_count + CNT_WIDTH'(1);
      end
   end

   // Next-state and output muxing
   always_comb begin
      state_next      = state;
      ptr_next        = ptr;
      cnt_inc         = 1'b0;
      last_addr_next  = last_addr;
      last_wdata_next = last_wdata;
      last_write_next = last_write;

      d_address     = P_mem_address;
      d_read        = P_mem_read;
      d_write       = P_mem_write;
      d_byte_enable = P_mem_byte_enable;
      d_wdata       = P_mem_wdata;
      P_mem_resp    = d_resp;
      P_mem_rdata   = d_rdata;

      unique case (state)
         IDLE: begin
            if (indirect && req) begin
               d_read          = 1'b1;
               d_write         = 1'b0;
               d_byte_enable   = 2'b11;
               P_mem_resp      = 1'b0;
               P_mem_rdata     = '0;
               last_addr_next  = P_mem_address;
               last_write_next = 1'b0;
               // A zero-wait pointer read skips PTR entirely
               if (d_resp) begin
                  ptr_next   = {d_rdata[15:1], 1'b0};
                  state_next = ACC;
               end else begin
                  state_next = PTR;
               end
            end
         end

         PTR: begin
            d_address     = last_addr;
            d_read        = 1'b1;
            d_write       = 1'b0;
            d_byte_enable = 2'b11;
            P_mem_resp    = 1'b0;
            P_mem_rdata   = '0;
            if (!req) begin
               state_next = d_resp ? IDLE : DRAIN;
            end else if (d_resp) begin
               ptr_next   = {d_rdata[15:1], 1'b0};
               state_next = ACC;
            end
         end

         ACC: begin
            d_address     = ptr;
            d_read        = P_mem_read;
            d_write       = wr_only;
            d_byte_enable = 2'b11;
            P_mem_resp    = 1'b0;
            P_mem_rdata   = '0;
            if (!req) begin
               state_next = d_resp ? IDLE : DRAIN;
            end else begin
               last_addr_next  = ptr;
               last_write_next = wr_only;
               last_wdata_next = P_mem_wdata;
               if (d_resp) begin
                  // Completion is suppressed if reset lands on this edge
                  P_mem_resp  = reset;
                  P_mem_rdata = reset ? d_rdata : '0;
                  cnt_inc     = 1'b1;
                  state_next  = IDLE;
               end
            end
         end

         DRAIN: begin
            d_address     = last_addr;
            d_read        = ~last_write;
            d_write       = last_write;
            d_byte_enable = 2'b11;
            d_wdata       = last_wdata;
            P_mem_resp    = 1'b0;
            P_mem_rdata   = '0;
            if (d_resp)
               state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_indirect_ctrl.sv
// Self-checking bench for indirect_ctrl: a behavioural cache with per-access
// random latency, and a transaction-level model of plain and indirect ops.
module tb_indirect_ctrl;
   import lc3b_types::*;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   lc3b_word      P_mem_address, P_mem_wdata, P_mem_rdata;
   logic          P_mem_read, P_mem_write, indirect, P_mem_resp;
   lc3b_mem_wmask P_mem_byte_enable, d_byte_enable;
   lc3b_word      d_address, d_wdata, d_rdata;
   logic          d_read, d_write, d_resp;
   logic [CW-1:0] indirect_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   indirect_ctrl #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .P_mem_address(P_mem_address), .P_mem_read(P_mem_read), .P_mem_write(P_mem_write),
      .P_mem_byte_enable(P_mem_byte_enable), .P_mem_wdata(P_mem_wdata), .indirect(indirect),
      .P_mem_resp(P_mem_resp), .P_mem_rdata(P_mem_rdata),
      .d_address(d_address), .d_read(d_read), .d_write(d_write),
      .d_byte_enable(d_byte_enable), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
      .indirect_count(indirect_count)
   );

   // ---------------- behavioural cache ----------------
   lc3b_word      mem [int];
   int            lat_q[$];
   int            cur_lat, waited;
   bit            in_access;
   lc3b_word      acc_addr;
   logic          acc_wr;
   bit            snap_resp, snap_wr;
   lc3b_word      snap_addr, snap_wdata;
   lc3b_mem_wmask snap_be;
   lc3b_word      log_addr[$], log_wdata[$];
   bit            log_wr[$];
   lc3b_mem_wmask log_be[$];
   int            model_cnt;

   function automatic lc3b_word mem_rd(input lc3b_word a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return a ^ 16'h5A5A;
   endfunction

   // Decide the cache response for the request currently on d_*
   task automatic drive_cache();
      #1;
      snap_resp = 1'b0;
      if (d_read === 1'b1 || d_write === 1'b1) begin
         if (!in_access || d_address !== acc_addr || d_write !== acc_wr) begin
            in_access = 1'b1;
            acc_addr  = d_address;
            acc_wr    = d_write;
            waited    = 0;
            cur_lat   = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
         end
         snap_addr  = d_address;
         snap_wr    = d_write;
         snap_wdata = d_wdata;
         snap_be    = d_byte_enable;
         if (waited >= cur_lat) begin
            snap_resp = 1'b1;
            d_resp    = 1'b1;
            d_rdata   = d_write ? 16'h0000 : mem_rd(d_address);
         end else begin
            d_resp  = 1'b0;
            d_rdata = 16'($urandom);
         end
      end else begin
         in_access = 1'b0;
         d_resp    = 1'b0;
         d_rdata   = 16'($urandom);
      end
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (snap_resp) begin
         log_addr.push_back(snap_addr);
         log_wr.push_back(snap_wr);
         log_wdata.push_back(snap_wdata);
         log_be.push_back(snap_be);
         if (snap_wr) mem[int'(snap_addr)] = snap_wdata;
         in_access = 1'b0;
      end else if (in_access) begin
         waited++;
      end
      snap_resp = 1'b0;
      #1;
   endtask

   function automatic void clear_logs();
      lat_q.delete(); log_addr.delete(); log_wr.delete(); log_wdata.delete(); log_be.delete();
   endfunction

   // One MEM-stage operation checked against the transaction-level model
   task automatic run_op(input string name, input logic ind, input logic rd, input logic wr,
                         input lc3b_word addr, input lc3b_word wdata, input int l1, input int l2);
      lc3b_word      p, exp_data, got;
      lc3b_word      e_addr[2], e_wd[2];
      bit            e_wr[2];
      lc3b_mem_wmask be, e_be[2];
      int            exp_n, exp_cycles, cyc, nresp;
      bit            bad_idle, first_ok;
      clear_logs();
      be = 2'($urandom);
      if (!ind) begin
         exp_n = 1; e_addr[0] = addr; e_wr[0] = wr; e_wd[0] = wdata; e_be[0] = be;
         exp_data = mem_rd(addr); exp_cycles = l1 + 1; lat_q.push_back(l1);
      end else begin
         p = mem_rd(addr) & 16'hFFFE;
         exp_n = 2;
         e_addr[0] = addr; e_wr[0] = 1'b0; e_wd[0] = 16'h0;  e_be[0] = 2'b11;
         e_addr[1] = p;    e_wr[1] = wr & ~rd; e_wd[1] = wdata; e_be[1] = 2'b11;
         exp_data = mem_rd(p); exp_cycles = l1 + l2 + 2;
         lat_q.push_back(l1); lat_q.push_back(l2);
         model_cnt = (model_cnt == (1 << CW) - 1) ? model_cnt : model_cnt + 1;
      end
      indirect = ind; P_mem_read = rd; P_mem_write = wr;
      P_mem_address = addr; P_mem_wdata = wdata; P_mem_byte_enable = be;
      cyc = 0; nresp = 0; bad_idle = 1'b0; first_ok = 1'b0; got = '0;
      while (nresp == 0 && cyc < 40) begin
         drive_cache();
         if (cyc == 0) begin
            if (!ind)
               first_ok = (d_address === addr && d_read === rd && d_write === wr &&
                           d_byte_enable === be && d_wdata === wdata);
            else
               first_ok = (d_address === addr && d_read === 1'b1 && d_write === 1'b0 &&
                           d_byte_enable === 2'b11);
         end
         if (P_mem_resp === 1'b1) begin
            nresp++; got = P_mem_rdata;
         end else if (ind && P_mem_rdata !== 16'h0) begin
            bad_idle = 1'b1;
         end
         if (!ind && (P_mem_resp !== d_resp || P_mem_rdata !== d_rdata)) bad_idle = 1'b1;
         cyc++;
         tick();
      end
      checks++;
      if (!first_ok) begin
         errors++;
         $display("FAIL %s first_cycle_request: got addr=%h rd=%b wr=%b be=%b want addr=%h", name,
                  d_address, d_read, d_write, d_byte_enable, addr);
      end
      checks++;
      if (nresp !== 1) begin errors++; $display("FAIL %s resp_pulses: got %0d want 1", name, nresp); end
      checks++;
      if (cyc !== exp_cycles) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_cycles);
      end
      checks++;
      if (bad_idle) begin errors++; $display("FAIL %s resp_rdata_while_busy: got 1 want 0", name); end
      if (rd) begin
         checks++;
         if (got !== exp_data) begin
            errors++; $display("FAIL %s rdata: got %h want %h", name, got, exp_data);
         end
      end
      checks++;
      if (log_addr.size() !== exp_n) begin
         errors++; $display("FAIL %s access_count: got %0d want %0d", name, log_addr.size(), exp_n);
      end else begin
         for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (log_addr[i] !== e_addr[i] || log_wr[i] !== e_wr[i] || log_be[i] !== e_be[i] ||
                (e_wr[i] && log_wdata[i] !== e_wd[i])) begin
               errors++;
               $display("FAIL %s access[%0d]: got addr=%h wr=%b be=%b wd=%h want addr=%h wr=%b be=%b wd=%h",
                        name, i, log_addr[i], log_wr[i], log_be[i], log_wdata[i],
                        e_addr[i], e_wr[i], e_be[i], e_wd[i]);
            end
         end
      end
      checks++;
      if (indirect_count !== CW'(model_cnt)) begin
         errors++; $display("FAIL %s count: got %0d want %0d", name, indirect_count, model_cnt);
      end
   endtask

   // Pass-through single cycle check used after reset/drain
   task automatic check_passthrough(input string name);
      lc3b_word a;
      clear_logs();
      a = 16'($urandom);
      lat_q.push_back(0);
      indirect = 1'b0; P_mem_read = 1'b1; P_mem_write = 1'b0; P_mem_address = a;
      drive_cache();
      checks++;
      if (d_address !== a || d_read !== 1'b1 || P_mem_resp !== 1'b1 || P_mem_rdata !== mem_rd(a)) begin
         errors++;
         $display("FAIL %s passthrough: got addr=%h rd=%b resp=%b rdata=%h want addr=%h rd=1 resp=1 rdata=%h",
                  name, d_address, d_read, P_mem_resp, P_mem_rdata, a, mem_rd(a));
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      indirect = 1'b1; P_mem_read = 1'b1; P_mem_write = 1'b0; P_mem_address = 16'h1111;
      P_mem_wdata = 16'h0; P_mem_byte_enable = 2'b00; d_resp = 1'b0; d_rdata = 16'h0;
      in_access = 1'b0; snap_resp = 1'b0; model_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      checks++;
      if (indirect_count !== '0) begin
         errors++; $display("FAIL reset_count: got %0d want 0", indirect_count);
      end
      check_passthrough("reset");
   endtask

   task automatic test_reset_in_acc();
      lc3b_word a;
      a = 16'($urandom);
      clear_logs();
      lat_q.push_back(0); lat_q.push_back(0);
      indirect = 1'b1; P_mem_read = 1'b1; P_mem_write = 1'b0; P_mem_address = a;
      drive_cache();
      tick();
      reset = 1'b0;
      drive_cache();
      checks++;
      if (P_mem_resp !== 1'b0) begin
         errors++; $display("FAIL reset_in_acc_resp: got %b want 0", P_mem_resp);
      end
      tick();
      reset = 1'b1;
      model_cnt = 0;
      checks++;
      if (indirect_count !== '0) begin
         errors++; $display("FAIL reset_in_acc_count: got %0d want 0", indirect_count);
      end
      check_passthrough("reset_in_acc");
   endtask

   task automatic test_drop_in_ptr();
      lc3b_word a;
      int       cyc, nresp;
      bit       held, seen;
      a = 16'($urandom);
      clear_logs();
      lat_q.push_back(3);
      indirect = 1'b1; P_mem_read = 1'b1; P_mem_write = 1'b0; P_mem_address = a;
      drive_cache();
      tick();
      P_mem_read = 1'b0; P_mem_address = a + 16'd2;
      cyc = 0; nresp = 0; held = 1'b1; seen = 1'b0;
      while (!seen && cyc < 20) begin
         drive_cache();
         if (d_read !== 1'b1 || d_address !== a) held = 1'b0;
         if (P_mem_resp !== 1'b0) nresp++;
         seen = (d_resp === 1'b1);
         cyc++;
         tick();
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL drop_drain_timeout: got 0 want 1"); end
      checks++;
      if (!held) begin errors++; $display("FAIL drop_drain_held: got 0 want 1"); end
      checks++;
      if (nresp !== 0) begin errors++; $display("FAIL drop_resp: got %0d want 0", nresp); end
      check_passthrough("drop_in_ptr");
      checks++;
      if (indirect_count !== CW'(model_cnt)) begin
         errors++; $display("FAIL drop_count: got %0d want %0d", indirect_count, model_cnt);
      end
   endtask

   task automatic test_directed();
      mem[32'h0040] = 16'h1234;
      run_op("plain_read", 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 3, 0);
      mem[32'h0040] = 16'h3001; mem[32'h3000] = 16'hBEEF;
      run_op("ldi", 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 2, 1);
      mem[32'h0050] = 16'h2000;
      run_op("sti", 1'b1, 1'b0, 1'b1, 16'h0050, 16'hA5A5, 1, 2);
      run_op("zero_wait_ldi", 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 0, 0);
      run_op("ldi_rw_as_read", 1'b1, 1'b1, 1'b1, 16'h0050, 16'h7777, 1, 0);
   endtask

   task automatic test_back_to_back();
      logic ind, rd, wr;
      int   sel;
      for (int i = 0; i < 30; i++) begin
         ind = (i % 3 != 0);
         sel = int'($urandom_range(0, 2));
         if (!ind) begin rd = (sel != 0); wr = ~rd; end
         else begin rd = (sel != 1); wr = (sel != 0); end
         run_op($sformatf("b2b_%0d", i), ind, rd, wr, 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_drop_in_ptr();
      test_reset_in_acc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
